// File: rtl/adc_scan_avg.sv
// Channel scan sequencer in front of the ADC128S022 SPI controller.
// Walks the enabled channels in ascending order, averages 2**AVG_LOG2
// conversions per channel and reports the truncated mean.
//
// state | meaning
// IDLE  | waiting for scan_en with a non-empty ch_mask
// START | one-cycle adc_start pulse for ch_q
// WAIT  | waiting for adc_done, bounded by TIMEOUT cycles
// EMIT  | res_valid strobe, advance to next enabled channel
// GAP   | SCAN_GAP idle cycles (at least one) before the next scan
module adc_scan_avg #(
  parameter int AVG_LOG2 = 2,
  parameter int SCAN_GAP = 1000,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  ch_mask,
  output logic        adc_start,
  output logic [2:0]  adc_channel,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic        res_valid,
  output logic [2:0]  res_channel,
  output logic [11:0] res_data,
  output logic        scan_done,
  output logic        timeout_err,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  // GAP always lasts at least one cycle, so SCAN_GAP=0 behaves like 1.
  localparam logic [GAP_W-1:0] GAP_LOAD = (SCAN_GAP > 0) ? GAP_W'(SCAN_GAP - 1) : '0;

  logic [2:0]       state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       ch_q, ch_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [11:0]      res_data_q, res_data_d;
  logic [2:0]       res_ch_q, res_ch_d;

  logic [2:0]       first_ch;
  logic [2:0]       nxt_ch;
  logic             nxt_vld;
  logic [ACC_W-1:0] sum_w;
  logic             scan_done_c;
  logic             timeout_c;

  // Lowest enabled channel of the live mask, used when a scan begins.
  always_comb begin
    first_ch = '0;
    for (int i = 7; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
    end
  end

  // Next enabled channel above the current one in the latched mask.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_ch  = ch_q;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i] && (3'(i) > ch_q)) begin
        nxt_vld = 1'b1;
        nxt_ch  = 3'(i);
      end
    end
  end

  assign sum_w = acc_q + ACC_W'(adc_data);

  // Sequencer next-state, accumulator and timer updates.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    smp_d       = smp_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    scan_done_c = 1'b0;
    timeout_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_en && (|ch_mask)) begin
          mask_d  = ch_mask;
          ch_d    = first_ch;
          acc_d   = '0;
          smp_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = TMO_LOAD;
        state_d = scan_en ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (adc_done) begin
          if (!scan_en) begin
            acc_d   = '0;
            smp_d   = '0;
            state_d = S_IDLE;
          end else if (smp_q == SMP_LAST) begin
            // Result is latched here so res_data is already stable in EMIT
            // and holds until the next result.
            res_data_d = sum_w[ACC_W-1:AVG_LOG2];
            res_ch_d   = ch_q;
            acc_d      = '0;
            smp_d      = '0;
            state_d    = S_EMIT;
          end else begin
            acc_d   = sum_w;
            smp_d   = smp_q + SMP_W'(1);
            state_d = S_START;
          end
        end else if (tmo_q == '0) begin
          timeout_c = 1'b1;
          acc_d     = '0;
          smp_d     = '0;
          if (!scan_en) begin
            state_d = S_IDLE;
          end else if (nxt_vld) begin
            ch_d    = nxt_ch;
            state_d = S_START;
          end else begin
            scan_done_c = 1'b1;
            gap_d       = GAP_LOAD;
            state_d     = S_GAP;
          end
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      S_EMIT: begin
        // The scan is complete regardless of scan_en; only the follow-on differs.
        scan_done_c = !nxt_vld;
        if (!scan_en) begin
          state_d = S_IDLE;
        end else if (nxt_vld) begin
          ch_d    = nxt_ch;
          state_d = S_START;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (!scan_en || (gap_q == '0)) state_d = S_IDLE;
        else                           gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      smp_q      <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      res_data_q <= '0;
      res_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      acc_q      <= acc_d;
      smp_q      <= smp_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
    end
  end

  assign adc_start   = (state_q == S_START);
  assign adc_channel = ch_q;
  assign res_valid   = (state_q == S_EMIT);
  assign res_channel = res_ch_q;
  assign res_data    = res_data_q;
  assign scan_done   = scan_done_c;
  assign timeout_err = timeout_c;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed bench for adc_scan_avg: table of full scans plus hand sequences
// for timeout, scan abort, empty mask and inter-scan gap.
module tb_adc_scan_avg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  ch_mask;
  logic        adc_start;
  logic [2:0]  adc_channel;
  logic        adc_done;
  logic [11:0] adc_data;
  logic        res_valid;
  logic [2:0]  res_channel;
  logic [11:0] res_data;
  logic        scan_done;
  logic        timeout_err;
  logic        busy;

  logic        scan_en4;
  logic [7:0]  ch_mask4;
  logic        adc_start4;
  logic [2:0]  adc_channel4;
  logic        adc_done4;
  logic [11:0] adc_data4;
  logic        res_valid4;
  logic [2:0]  res_channel4;
  logic [11:0] res_data4;
  logic        scan_done4;
  logic        timeout_err4;
  logic        busy4;

  always #5 clk = ~clk;

  adc_scan_avg #(.AVG_LOG2(2), .SCAN_GAP(1000), .TIMEOUT(1024)) u_dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .ch_mask(ch_mask),
    .adc_start(adc_start), .adc_channel(adc_channel), .adc_done(adc_done),
    .adc_data(adc_data), .res_valid(res_valid), .res_channel(res_channel),
    .res_data(res_data), .scan_done(scan_done), .timeout_err(timeout_err), .busy(busy)
  );

  adc_scan_avg #(.AVG_LOG2(4), .SCAN_GAP(0), .TIMEOUT(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en4), .ch_mask(ch_mask4),
    .adc_start(adc_start4), .adc_channel(adc_channel4), .adc_done(adc_done4),
    .adc_data(adc_data4), .res_valid(res_valid4), .res_channel(res_channel4),
    .res_data(res_data4), .scan_done(scan_done4), .timeout_err(timeout_err4), .busy(busy4)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  // ADC responder model for the main instance
  logic [11:0] dtab [4];
  logic [7:0]  wh_mask = 8'h00;
  int          inj_req = 0;
  int          inj_ack = 0;
  int          n_done = 0;
  int          chan_err = 0;
  bit          pend = 0;
  int          lat = 0;
  logic [2:0]  pend_ch = '0;

  always @(posedge clk) begin
    #1;
    adc_done = 1'b0;
    if (inj_req != inj_ack) begin
      adc_done = 1'b1;
      adc_data = 12'h0AA;
      inj_ack++;
    end else if (pend) begin
      if (lat == 0) begin
        adc_done = 1'b1;
        adc_data = dtab[n_done % 4];
        n_done++;
        pend = 0;
        if (adc_channel != pend_ch) chan_err++;
      end else begin
        lat--;
      end
    end else if (rst_n && adc_start && !wh_mask[adc_channel]) begin
      pend = 1;
      lat = 2;
      pend_ch = adc_channel;
    end
  end

  // Responder for the 16-sample instance: always full scale
  bit pend4 = 0;
  always @(posedge clk) begin
    #1;
    adc_done4 = 1'b0;
    if (pend4) begin
      adc_done4 = 1'b1;
      pend4 = 0;
    end else if (rst_n && adc_start4) begin
      pend4 = 1;
    end
  end

  // Output monitors
  int         n_start = 0, n_sd = 0, n_tmo = 0, busy_seen = 0;
  int         start_cyc [8];
  int         last_start_cyc = 0, sd_cyc = 0, tmo_cyc = 0;
  bit         sd_with_tmo = 0;
  logic [2:0] rq_ch [$];
  logic [11:0] rq_dat [$];
  bit         rq_sd [$];
  int         n_res4 = 0;
  logic [11:0] last_res4 = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (adc_start) begin
        n_start++;
        start_cyc[adc_channel] = cyc;
        last_start_cyc = cyc;
      end
      if (scan_done) begin
        n_sd++;
        sd_cyc = cyc;
      end
      if (timeout_err) begin
        n_tmo++;
        tmo_cyc = cyc;
        sd_with_tmo = scan_done;
      end
      if (res_valid) begin
        rq_ch.push_back(res_channel);
        rq_dat.push_back(res_data);
        rq_sd.push_back(scan_done);
      end
      if (busy) busy_seen++;
      if (res_valid4) begin
        n_res4++;
        last_res4 = res_data4;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired, got no event expected one", nm);
  endtask

  task automatic wait_scan_done(input string nm, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (scan_done) break;
    end
    if (i == bound) bound_fail(nm);
  endtask

  typedef struct packed {
    logic [7:0]       mask;
    logic [3:0][11:0] d;
    logic [3:0]       exp_n;
    logic [11:0]      exp_avg;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] m, input logic [11:0] a, b, c, e,
                              input logic [3:0] n, input logic [11:0] avg);
    vec_t v;
    v.mask = m;
    v.d[0] = a;
    v.d[1] = b;
    v.d[2] = c;
    v.d[3] = e;
    v.exp_n = n;
    v.exp_avg = avg;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int base, ns, nsd, nt, k, rb, i;

    vecs[0] = mk(8'h05, 12'd100, 12'd101, 12'd102, 12'd105, 4'd2, 12'd102);
    vecs[1] = mk(8'h80, 12'd0,   12'd0,   12'd0,   12'd3,   4'd1, 12'd0);
    vecs[2] = mk(8'h12, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'd2, 12'hFFF);
    vecs[3] = mk(8'h01, 12'd1,   12'd2,   12'd3,   12'd4,   4'd1, 12'd2);
    vecs[4] = mk(8'hFF, 12'd10,  12'd20,  12'd30,  12'd41,  4'd8, 12'd25);
    vecs[5] = mk(8'h28, 12'd7,   12'd7,   12'd7,   12'd6,   4'd2, 12'd6);

    rst_n = 1'b0;
    scan_en = 1'b0;
    ch_mask = 8'h00;
    scan_en4 = 1'b0;
    ch_mask4 = 8'h01;
    adc_data = 12'h000;
    adc_data4 = 12'hFFF;
    for (int j = 0; j < 4; j++) dtab[j] = 12'd0;
    repeat (3) @(negedge clk);
    chk("rst_adc_start", 32'(adc_start), 0);
    chk("rst_adc_channel", 32'(adc_channel), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_channel", 32'(res_channel), 0);
    chk("rst_res_data", 32'(res_data), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 16-sample averaging of full-scale data
    scan_en4 = 1'b1;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (scan_done4) break;
    end
    if (i == 400) bound_fail("avg16_wait");
    @(negedge clk);
    scan_en4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("avg16_count", 32'(n_res4), 1);
    chk("avg16_data", 32'(last_res4), 32'hFFF);

    // Table of complete scans
    for (int v = 0; v < 6; v++) begin
      base = rq_ch.size();
      ns = n_start;
      nsd = n_sd;
      nt = n_tmo;
      for (int j = 0; j < 4; j++) dtab[j] = vecs[v].d[j];
      ch_mask = vecs[v].mask;
      scan_en = 1'b1;
      wait_scan_done($sformatf("v%0d_wait", v), 3000);
      @(negedge clk);
      scan_en = 1'b0;
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_count", v), 32'(rq_ch.size() - base), 32'(vecs[v].exp_n));
      chk($sformatf("v%0d_starts", v), 32'(n_start - ns), 32'(vecs[v].exp_n) * 4);
      chk($sformatf("v%0d_scan_done", v), 32'(n_sd - nsd), 1);
      chk($sformatf("v%0d_timeouts", v), 32'(n_tmo - nt), 0);
      chk($sformatf("v%0d_idle", v), 32'(busy), 0);
      k = 0;
      for (int c = 0; c < 8; c++) begin
        if (vecs[v].mask[c]) begin
          if (base + k < rq_ch.size()) begin
            chk($sformatf("v%0d_r%0d_ch", v, k), 32'(rq_ch[base + k]), 32'(c));
            chk($sformatf("v%0d_r%0d_data", v, k), 32'(rq_dat[base + k]), 32'(vecs[v].exp_avg));
            chk($sformatf("v%0d_r%0d_sd", v, k), 32'(rq_sd[base + k]),
                (k == int'(vecs[v].exp_n) - 1) ? 32'd1 : 32'd0);
          end
          k++;
        end
      end
    end

    // Empty mask with scanning enabled: nothing happens
    ns = n_start;
    rb = busy_seen;
    ch_mask = 8'h00;
    scan_en = 1'b1;
    repeat (5000) @(negedge clk);
    scan_en = 1'b0;
    chk("mask0_starts", 32'(n_start - ns), 0);
    chk("mask0_busy", 32'(busy_seen - rb), 0);

    // Channel 1 never answers: timeout, skip, scan still completes
    base = rq_ch.size();
    nsd = n_sd;
    nt = n_tmo;
    dtab[0] = 12'd100; dtab[1] = 12'd101; dtab[2] = 12'd102; dtab[3] = 12'd105;
    wh_mask = 8'h02;
    ch_mask = 8'h03;
    scan_en = 1'b1;
    wait_scan_done("tmo_wait", 3000);
    @(negedge clk);
    scan_en = 1'b0;
    repeat (5) @(negedge clk);
    wh_mask = 8'h00;
    chk("tmo_count", 32'(n_tmo - nt), 1);
    chk("tmo_latency", 32'(tmo_cyc - start_cyc[1]), 1024);
    chk("tmo_scan_done_same_cycle", 32'(sd_with_tmo), 1);
    chk("tmo_scan_done_count", 32'(n_sd - nsd), 1);
    chk("tmo_res_count", 32'(rq_ch.size() - base), 1);
    if (rq_ch.size() > base) begin
      chk("tmo_res_ch", 32'(rq_ch[base]), 0);
      chk("tmo_res_data", 32'(rq_dat[base]), 102);
    end

    // scan_en dropped while ch3 conversion is in flight
    base = rq_ch.size();
    ns = n_start;
    ch_mask = 8'h08;
    scan_en = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_start) break;
    end
    if (i == 50) bound_fail("abort_start_wait");
    @(negedge clk);
    scan_en = 1'b0;
    for (i = 0; i < 50; i++) begin
      if (adc_done) break;
      @(negedge clk);
    end
    if (i == 50) bound_fail("abort_done_wait");
    chk("abort_busy_at_done", 32'(busy), 1);
    @(negedge clk);
    chk("abort_idle_after_done", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("abort_res_count", 32'(rq_ch.size() - base), 0);
    chk("abort_starts", 32'(n_start - ns), 1);

    // Gap length and adc_done injected during GAP
    dtab[0] = 12'd100; dtab[1] = 12'd101; dtab[2] = 12'd102; dtab[3] = 12'd105;
    ch_mask = 8'h01;
    scan_en = 1'b1;
    wait_scan_done("gap_wait_sd", 500);
    repeat (10) @(negedge clk);
    rb = rq_ch.size();
    ns = n_start;
    chk("gap_busy", 32'(busy), 1);
    inj_req++;
    for (i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (n_start > ns) break;
    end
    if (i == 1500) bound_fail("gap_wait_start");
    chk("gap_to_start", 32'(last_start_cyc - sd_cyc), 1002);
    chk("gap_inject_res_count", 32'(rq_ch.size() - rb), 0);
    chk("gap_inject_consumed", 32'(inj_ack), 32'(inj_req));
    scan_en = 1'b0;
    repeat (20) @(negedge clk);

    chk("chan_stable_errors", 32'(chan_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
